// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared types and constants for the single-precision add/sub
//               arbiter and its combinational adder.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] FP_EXP_MAX = 8'hFF;
    localparam logic       OP_ADD     = 1'b0;
    localparam logic       OP_SUB     = 1'b1;

    // Leading-zero count of the 28-bit adder sum; 28 when the sum is zero.
    function automatic logic [4:0] clz28(input logic [27:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd28;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(27 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cong_tru.sv
`default_nettype none
// ============================================================================
// Module      : cong_tru
// Description : Combinational IEEE-754 single-precision add/subtract,
//               round-to-nearest-even, subnormals flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module cong_tru
    import fp_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_op,
    output logic [31:0] o_result
);

    logic               w_signA, w_signB, w_signL, w_signS, w_swap;
    logic [7:0]         w_expA, w_expB, w_expL, w_expS, w_expDiff;
    logic [22:0]        w_fracA, w_fracB, w_fracL, w_fracS, w_fracOut;
    logic [23:0]        w_mantL, w_mantS;
    logic [26:0]        w_mantLx, w_mantSx, w_aligned, w_lostMask;
    logic [27:0]        w_sum, w_norm;
    logic [4:0]         w_lzc;
    logic [23:0]        w_mant24;
    logic               w_guard, w_sticky, w_roundUp;
    logic [24:0]        w_rounded;
    logic signed [9:0]  w_exp10, w_expFinal;

    always_comb begin
        w_signA = i_a[31];
        w_signB = i_b[31] ^ (i_op == OP_SUB);
        w_expA  = i_a[30:23];
        w_expB  = i_b[30:23];
        w_fracA = (w_expA == 8'h00) ? 23'h0 : i_a[22:0];
        w_fracB = (w_expB == 8'h00) ? 23'h0 : i_b[22:0];

        // Order by magnitude so the subtraction below never goes negative.
        w_swap  = {w_expB, w_fracB} > {w_expA, w_fracA};
        w_signL = w_swap ? w_signB : w_signA;
        w_signS = w_swap ? w_signA : w_signB;
        w_expL  = w_swap ? w_expB  : w_expA;
        w_expS  = w_swap ? w_expA  : w_expB;
        w_fracL = w_swap ? w_fracB : w_fracA;
        w_fracS = w_swap ? w_fracA : w_fracB;
        w_mantL = {w_expL != 8'h00, w_fracL};
        w_mantS = {w_expS != 8'h00, w_fracS};

        w_expDiff  = w_expL - w_expS;
        w_mantLx   = {w_mantL, 3'b000};
        w_mantSx   = {w_mantS, 3'b000};
        w_lostMask = ~(27'h7FF_FFFF << w_expDiff);
        // Guard, round and sticky bits: anything shifted out ORs into bit 0.
        if (w_expDiff >= 8'd27) begin
            w_aligned = {26'h0, |w_mantS};
        end else begin
            w_aligned = (w_mantSx >> w_expDiff) | {26'h0, |(w_mantSx & w_lostMask)};
        end

        if (w_signL == w_signS) begin
            w_sum = {1'b0, w_mantLx} + {1'b0, w_aligned};
        end else begin
            w_sum = {1'b0, w_mantLx} - {1'b0, w_aligned};
        end

        w_lzc     = clz28(w_sum);
        w_norm    = w_sum << w_lzc;
        w_exp10   = $signed({2'b00, w_expL}) + 10'sd1 - $signed({5'b00000, w_lzc});
        w_mant24  = w_norm[27:4];
        w_guard   = w_norm[3];
        w_sticky  = |w_norm[2:0];
        w_roundUp = w_guard & (w_sticky | w_mant24[0]);
        w_rounded = {1'b0, w_mant24} + {24'h0, w_roundUp};

        w_expFinal = w_exp10 + $signed({9'h000, w_rounded[24]});
        w_fracOut  = w_rounded[24] ? w_rounded[23:1] : w_rounded[22:0];

        if (w_sum == 28'h0) begin
            o_result = {w_signL & w_signS, 31'h0};
        end else if (w_expFinal >= 10'sd255) begin
            o_result = {w_signL, FP_EXP_MAX, 23'h0};
        end else if (w_expFinal <= 10'sd0) begin
            o_result = {w_signL, 31'h0};
        end else begin
            o_result = {w_signL, w_expFinal[7:0], w_fracOut};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_arbiter
// Description : Round-robin sharing of one cong_tru adder between two
//               requesters, one operation in flight, registered response.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_arbiter
    import fp_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_op,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_op,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic             rsp0_exc,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic             rsp1_exc,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             busy,
    output logic [15:0]      op_count
);

    state_t           r_state, w_nextState;
    logic [31:0]      r_opA, r_opB, r_result, w_adderResult;
    logic             r_op, r_owner, r_exc, r_lastGrant;
    logic [TAG_W-1:0] r_tag;
    logic [15:0]      r_opCount;

    logic             w_grant0, w_grant1, w_accept, w_rspHandshake;
    logic [31:0]      w_selA, w_selB;
    logic             w_selOp, w_selExc;
    logic [TAG_W-1:0] w_selTag;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE && !rst) begin
            // On a tie the requester that did not win last time goes first.
            if (req0_valid && req1_valid) begin
                w_grant0 = r_lastGrant;
                w_grant1 = ~r_lastGrant;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign w_accept       = w_grant0 | w_grant1;
    assign w_rspHandshake = (r_state == HOLD) && (r_owner ? rsp1_ready : rsp0_ready);

    assign w_selA   = w_grant1 ? req1_a   : req0_a;
    assign w_selB   = w_grant1 ? req1_b   : req0_b;
    assign w_selOp  = w_grant1 ? req1_op  : req0_op;
    assign w_selTag = w_grant1 ? req1_tag : req0_tag;
    assign w_selExc = (w_selA[30:23] == FP_EXP_MAX) | (w_selB[30:23] == FP_EXP_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = EXEC;
            EXEC:    w_nextState = HOLD;
            HOLD:    if (w_rspHandshake) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        rsp0_valid = (r_state == HOLD) && !r_owner;
        rsp1_valid = (r_state == HOLD) &&  r_owner;
        busy       = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA       <= 32'h0;
            r_opB       <= 32'h0;
            r_op        <= 1'b0;
            r_tag       <= '0;
            r_owner     <= 1'b0;
            r_exc       <= 1'b0;
            r_lastGrant <= 1'b1;
            r_result    <= 32'h0;
            r_opCount   <= 16'h0;
        end else begin
            if (w_accept) begin
                r_opA       <= w_selA;
                r_opB       <= w_selB;
                r_op        <= w_selOp;
                r_tag       <= w_selTag;
                r_owner     <= w_grant1;
                r_exc       <= w_selExc;
                r_lastGrant <= w_grant1;
            end
            if (r_state == EXEC) begin
                r_result <= r_exc ? 32'h0 : w_adderResult;
            end
            if (w_rspHandshake) begin
                r_opCount <= r_opCount + 16'h1;
            end
        end
    end

    cong_tru u_adder (
        .i_a      (r_opA),
        .i_b      (r_opB),
        .i_op     (r_op),
        .o_result (w_adderResult)
    );

    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_exc    = r_exc;
    assign rsp1_exc    = r_exc;
    assign rsp0_tag    = r_tag;
    assign rsp1_tag    = r_tag;
    assign op_count    = r_opCount;

endmodule
`default_nettype wire
